// File: rtl/uart_rx_packetizer_if.sv
// Packet output channel of the UART RX packetizer: wide data word with a valid/ready handshake.
interface uart_rx_packetizer_if #(
  parameter int unsigned PACKET_BYTES = 2
);
  localparam int unsigned PKT_W = 8 * PACKET_BYTES;

  logic [PKT_W-1:0] pkt_data;
  logic             pkt_valid;
  logic             pkt_ready;

  modport master (output pkt_data, output pkt_valid, input pkt_ready);
  modport slave  (input pkt_data, input pkt_valid, output pkt_ready);
endinterface

// File: rtl/uart_rx_packetizer.sv
// Assembles consecutive UART bytes into PACKET_BYTES-wide packets, first byte in the MSBs.
// Partial packets are dropped on inter-byte timeout or framing error; drops raise sticky flags.
module uart_rx_packetizer #(
  parameter int unsigned PACKET_BYTES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 52_083
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_done,
  input  logic                  rx_framing_error,
  input  logic                  clear_errors,
  output logic [2:0]            byte_count,
  output logic                  overrun,
  output logic                  timeout,
  output logic                  frame_err,
  uart_rx_packetizer_if.master  pkt_if
);

  localparam int unsigned PKT_W = 8 * PACKET_BYTES;
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    RESYNC  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PKT_W-1:0]   shift_q, shift_d;
  logic [PKT_W-1:0]   pkt_data_q, pkt_data_d;
  logic               pkt_valid_q, pkt_valid_d;
  logic [2:0]         byte_count_q, byte_count_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               overrun_q, overrun_d;
  logic               timeout_q, timeout_d;
  logic               frame_err_q, frame_err_d;

  logic accept_c;
  logic last_c;
  logic expire_c;
  logic hs_c;

  // Framing error beats rx_done, which beats timer expiry.
  assign accept_c = rx_done && !rx_framing_error && (state_q != RESYNC);
  assign last_c   = accept_c && (byte_count_q == 3'(PACKET_BYTES - 1));
  assign expire_c = (state_q == COLLECT) && !rx_framing_error && !rx_done &&
                    (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));
  assign hs_c     = pkt_valid_q && pkt_if.pkt_ready;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (rx_framing_error) begin
      state_d = RESYNC;
    end else begin
      unique case (state_q)
        IDLE:    if (accept_c && !last_c) state_d = COLLECT;
        COLLECT: if (last_c || expire_c)  state_d = IDLE;
        RESYNC:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath and flag next-state logic.
  always_comb begin
    logic complete;
    logic set_overrun;
    logic set_timeout;
    logic set_frame;

    shift_d      = shift_q;
    pkt_data_d   = pkt_data_q;
    pkt_valid_d  = pkt_valid_q;
    byte_count_d = byte_count_q;
    timer_d      = timer_q;
    complete     = 1'b0;
    set_overrun  = 1'b0;
    set_timeout  = 1'b0;
    set_frame    = 1'b0;

    if (rx_framing_error) begin
      shift_d      = '0;
      byte_count_d = '0;
      timer_d      = '0;
      set_frame    = (state_q != RESYNC);
    end else if (accept_c) begin
      shift_d = PKT_W'({shift_q, rx_data});
      timer_d = '0;
      if (last_c) begin
        byte_count_d = '0;
        complete     = 1'b1;
      end else begin
        byte_count_d = byte_count_q + 3'd1;
      end
    end else if (state_q == COLLECT) begin
      if (expire_c) begin
        shift_d      = '0;
        byte_count_d = '0;
        timer_d      = '0;
        set_timeout  = 1'b1;
      end else begin
        timer_d = timer_q + TMR_W'(1);
      end
    end

    // A completed packet needs the output register free, or freed by this cycle's handshake.
    if (complete) begin
      if (!pkt_valid_q || hs_c) begin
        pkt_data_d  = shift_d;
        pkt_valid_d = 1'b1;
      end else begin
        set_overrun = 1'b1;
      end
    end else if (hs_c) begin
      pkt_valid_d = 1'b0;
    end

    overrun_d   = (clear_errors ? 1'b0 : overrun_q)   | set_overrun;
    timeout_d   = (clear_errors ? 1'b0 : timeout_q)   | set_timeout;
    frame_err_d = (clear_errors ? 1'b0 : frame_err_q) | set_frame;
  end

  // Datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      shift_q      <= '0;
      pkt_data_q   <= '0;
      pkt_valid_q  <= 1'b0;
      byte_count_q <= '0;
      timer_q      <= '0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      shift_q      <= shift_d;
      pkt_data_q   <= pkt_data_d;
      pkt_valid_q  <= pkt_valid_d;
      byte_count_q <= byte_count_d;
      timer_q      <= timer_d;
      overrun_q    <= overrun_d;
      timeout_q    <= timeout_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign pkt_if.pkt_data  = pkt_data_q;
  assign pkt_if.pkt_valid = pkt_valid_q;
  assign byte_count       = byte_count_q;
  assign overrun          = overrun_q;
  assign timeout          = timeout_q;
  assign frame_err        = frame_err_q;

endmodule

// File: tb/tb_uart_rx_packetizer.sv
// Directed bench for uart_rx_packetizer: a 2-byte instance for the main scenarios and a
// 1-byte instance for single-byte packets; every check goes through one compare task.
module tb_uart_rx_packetizer;

  localparam int unsigned TMO = 100;

  logic       clock;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_framing_error;
  logic       clear_errors;
  logic [2:0] byte_count;
  logic       overrun;
  logic       timeout;
  logic       frame_err;

  logic [7:0] rx_data1;
  logic       rx_done1;
  logic       zero1;
  logic [2:0] byte_count1;
  logic       overrun1;
  logic       timeout1;
  logic       frame_err1;

  int total;
  int bad;

  uart_rx_packetizer_if #(.PACKET_BYTES(2)) pkt2 ();
  uart_rx_packetizer_if #(.PACKET_BYTES(1)) pkt1 ();

  uart_rx_packetizer #(.PACKET_BYTES(2), .TIMEOUT_CYCLES(TMO)) dut2 (
    .clock            (clock),
    .reset            (reset),
    .rx_data          (rx_data),
    .rx_done          (rx_done),
    .rx_framing_error (rx_framing_error),
    .clear_errors     (clear_errors),
    .byte_count       (byte_count),
    .overrun          (overrun),
    .timeout          (timeout),
    .frame_err        (frame_err),
    .pkt_if           (pkt2.master)
  );

  uart_rx_packetizer #(.PACKET_BYTES(1), .TIMEOUT_CYCLES(TMO)) dut1 (
    .clock            (clock),
    .reset            (reset),
    .rx_data          (rx_data1),
    .rx_done          (rx_done1),
    .rx_framing_error (zero1),
    .clear_errors     (zero1),
    .byte_count       (byte_count1),
    .overrun          (overrun1),
    .timeout          (timeout1),
    .frame_err        (frame_err1),
    .pkt_if           (pkt1.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Advance one edge, then settle so outputs are sampled away from it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  task automatic send1(input logic [7:0] b);
    rx_data1 = b;
    rx_done1 = 1'b1;
    tick();
    rx_done1 = 1'b0;
  endtask

  task automatic check_flags(input string tag, input logic [2:0] exp);
    check(tag, {overrun, timeout, frame_err}, exp);
  endtask

  task automatic pulse_clear();
    clear_errors = 1'b1;
    tick();
    clear_errors = 1'b0;
  endtask

  initial begin
    total            = 0;
    bad              = 0;
    reset            = 1'b1;
    rx_data          = 8'h00;
    rx_done          = 1'b0;
    rx_framing_error = 1'b0;
    clear_errors     = 1'b0;
    rx_data1         = 8'h00;
    rx_done1         = 1'b0;
    zero1            = 1'b0;
    pkt2.pkt_ready   = 1'b0;
    pkt1.pkt_ready   = 1'b1;
    ticks(2);
    reset = 1'b0;

    check("rst_data",  pkt2.pkt_data, 64'h0);
    check("rst_valid", pkt2.pkt_valid, 64'h0);
    check("rst_count", byte_count, 64'h0);
    check_flags("rst_flags", 3'b000);

    // Basic two-byte packet with consumer ready.
    pkt2.pkt_ready = 1'b1;
    send(8'hA5);
    check("t1_count", byte_count, 64'h1);
    check("t1_valid_early", pkt2.pkt_valid, 64'h0);
    send(8'h3C);
    check("t1_valid", pkt2.pkt_valid, 64'h1);
    check("t1_data", pkt2.pkt_data, 64'hA53C);
    check("t1_count0", byte_count, 64'h0);
    tick();
    check("t1_valid_drop", pkt2.pkt_valid, 64'h0);
    check_flags("t1_flags", 3'b000);

    // Output stalled: second packet is dropped as overrun.
    pkt2.pkt_ready = 1'b0;
    send(8'h11);
    send(8'h22);
    send(8'h33);
    send(8'h44);
    check("t2_data_hold", pkt2.pkt_data, 64'h1122);
    check("t2_valid_hold", pkt2.pkt_valid, 64'h1);
    check_flags("t2_overrun", 3'b100);
    pkt2.pkt_ready = 1'b1;
    tick();
    check("t2_valid_hs", pkt2.pkt_valid, 64'h0);
    pulse_clear();
    check_flags("t2_clear", 3'b000);

    // Inter-byte timeout drops the partial packet.
    send(8'h55);
    ticks(TMO - 1);
    check_flags("t3_not_yet", 3'b000);
    check("t3_count_held", byte_count, 64'h1);
    tick();
    check_flags("t3_timeout", 3'b010);
    check("t3_count0", byte_count, 64'h0);
    send(8'h01);
    send(8'h02);
    check("t3_data", pkt2.pkt_data, 64'h0102);
    check("t3_valid", pkt2.pkt_valid, 64'h1);
    tick();
    pulse_clear();

    // Framing error with a byte arriving inside it.
    send(8'h77);
    rx_framing_error = 1'b1;
    tick();
    check_flags("t4_frame", 3'b001);
    check("t4_count0", byte_count, 64'h0);
    ticks(9);
    send(8'h99);
    ticks(9);
    check("t4_count_fe", byte_count, 64'h0);
    check("t4_no_pkt", pkt2.pkt_valid, 64'h0);
    rx_framing_error = 1'b0;
    tick();
    send(8'hDE);
    send(8'hAD);
    check("t4_data", pkt2.pkt_data, 64'hDEAD);
    check("t4_valid", pkt2.pkt_valid, 64'h1);
    tick();
    pulse_clear();
    check_flags("t4_clear", 3'b000);

    // Completion coincident with handshake reloads without overrun.
    pkt2.pkt_ready = 1'b0;
    send(8'h10);
    send(8'h20);
    check("t5_first", pkt2.pkt_data, 64'h1020);
    send(8'h30);
    pkt2.pkt_ready = 1'b1;
    send(8'h40);
    check("t5_reload_data", pkt2.pkt_data, 64'h3040);
    check("t5_reload_valid", pkt2.pkt_valid, 64'h1);
    check_flags("t5_no_overrun", 3'b000);
    tick();
    check("t5_drain", pkt2.pkt_valid, 64'h0);

    // Clear coincident with timer expiry: the new timeout wins.
    send(8'h66);
    ticks(TMO - 1);
    clear_errors = 1'b1;
    tick();
    clear_errors = 1'b0;
    check_flags("t5_clear_vs_tmo", 3'b010);
    pulse_clear();
    check_flags("t5_cleared", 3'b000);

    // Reset mid-packet with a held output word.
    pkt2.pkt_ready = 1'b0;
    send(8'h01);
    send(8'h02);
    send(8'h12);
    check("t6_pre_count", byte_count, 64'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_rst_data", pkt2.pkt_data, 64'h0);
    check("t6_rst_valid", pkt2.pkt_valid, 64'h0);
    check("t6_rst_count", byte_count, 64'h0);
    pkt2.pkt_ready = 1'b1;
    send(8'hBE);
    send(8'hEF);
    check("t6_data", pkt2.pkt_data, 64'hBEEF);
    tick();

    // Single-byte packets, back to back.
    send1(8'hA5);
    check("p1_data_a", pkt1.pkt_data, 64'hA5);
    check("p1_valid_a", pkt1.pkt_valid, 64'h1);
    check("p1_count", byte_count1, 64'h0);
    send1(8'h3C);
    check("p1_data_b", pkt1.pkt_data, 64'h3C);
    check("p1_valid_b", pkt1.pkt_valid, 64'h1);
    tick();
    check("p1_drain", pkt1.pkt_valid, 64'h0);
    check("p1_flags", {overrun1, timeout1, frame_err1}, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
